// File: rtl/pipelined_adds_arbiter.sv
// Round-robin front end that shares one pipelined adder among NUM_REQ requesters
// and steers each returning result back to the requester that issued it.
module pipelined_adds_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 16,
  parameter int LATENCY = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*WIDTH-1:0]     req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic                         pause,
  output logic                         add_in_valid,
  output logic [WIDTH-1:0]             add_in_data,
  input  logic [WIDTH-1:0]             add_result,
  output logic [NUM_REQ-1:0]           rsp_valid,
  output logic [WIDTH-1:0]             rsp_data,
  output logic [$clog2(LATENCY+1)-1:0] in_flight
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(LATENCY+1);

  logic [IDX_W-1:0]              last_grant_reg;
  logic [IDX_W-1:0]              last_grant_next;
  logic                          grant_found;
  logic                          grant_valid;
  logic [IDX_W-1:0]              grant_idx;
  logic [IDX_W:0]                cand;
  logic [WIDTH-1:0]              operand [NUM_REQ];

  logic [LATENCY-1:0]            tag_valid_reg;
  logic [LATENCY-1:0]            tag_valid_next;
  logic [LATENCY-1:0][IDX_W-1:0] tag_idx_reg;
  logic [LATENCY-1:0][IDX_W-1:0] tag_idx_next;
  logic [CNT_W-1:0]              occupancy;

  genvar gi;

  // Unpack the flat operand bus and decode the one-hot grant per requester.
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign operand[gi]   = req_data[gi*WIDTH +: WIDTH];
      assign req_ready[gi] = grant_valid && (grant_idx == IDX_W'(gi));
    end
  endgenerate

  // Rotating priority search: the requester just after the last grant goes first.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, last_grant_reg} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(NUM_REQ))
        cand = cand - (IDX_W+1)'(NUM_REQ);
      if (!grant_found && req_valid[cand[IDX_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[IDX_W-1:0];
      end
    end
  end

  // Held reset masks the grant so nothing leaks to the adder before release.
  assign grant_valid  = grant_found && !pause && rst;
  assign add_in_valid = grant_valid;
  assign add_in_data  = grant_valid ? operand[grant_idx] : '0;

  assign last_grant_next = grant_valid ? grant_idx : last_grant_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant_reg <= IDX_W'(NUM_REQ-1);
    end else begin
      last_grant_reg <= last_grant_next;
    end
  end

  // Tag pipeline mirrors the adder latency; bubbles travel as valid=0.
  generate
    for (gi = 0; gi < LATENCY; gi++) begin : g_tag
      if (gi == 0) begin : g_head
        assign tag_valid_next[gi] = grant_valid;
        assign tag_idx_next[gi]   = grant_idx;
      end else begin : g_body
        assign tag_valid_next[gi] = tag_valid_reg[gi-1];
        assign tag_idx_next[gi]   = tag_idx_reg[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_valid_reg <= '0;
      tag_idx_reg   <= '0;
    end else begin
      tag_valid_reg <= tag_valid_next;
      tag_idx_reg   <= tag_idx_next;
    end
  end

  always_comb begin
    occupancy = '0;
    for (int k = 0; k < LATENCY; k++)
      occupancy = occupancy + CNT_W'(tag_valid_reg[k]);
  end

  assign in_flight = occupancy;
  assign rsp_valid = tag_valid_reg[LATENCY-1]
                     ? (NUM_REQ'(1) << tag_idx_reg[LATENCY-1]) : '0;
  assign rsp_data  = add_result;

endmodule

// File: tb/tb_pipelined_adds_arbiter.sv
// Bench for pipelined_adds_arbiter: two instances (latency 1 and 4) share stimulus,
// each fed by a registered in+2 adder model; results tracked in per-instance queues.
module tb_pipelined_adds_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [3:0]  req_valid;
  logic        pause;
  logic [15:0] dat [4];
  logic [63:0] req_data;
  assign req_data = {dat[3], dat[2], dat[1], dat[0]};

  logic [3:0]  ready1, ready4, rsp_v1, rsp_v4;
  logic        aiv1, aiv4;
  logic [15:0] aid1, aid4, res1, res4, rsp_d1, rsp_d4;
  logic [0:0]  inf1;
  logic [2:0]  inf4;
  logic [15:0] pipe4 [4];

  pipelined_adds_arbiter #(.NUM_REQ(4), .WIDTH(16), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(ready1), .pause(pause), .add_in_valid(aiv1), .add_in_data(aid1),
    .add_result(res1), .rsp_valid(rsp_v1), .rsp_data(rsp_d1), .in_flight(inf1)
  );

  pipelined_adds_arbiter #(.NUM_REQ(4), .WIDTH(16), .LATENCY(4)) dut4 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(ready4), .pause(pause), .add_in_valid(aiv4), .add_in_data(aid4),
    .add_result(res4), .rsp_valid(rsp_v4), .rsp_data(rsp_d4), .in_flight(inf4)
  );

  // Adder models: registered in+2 with latency 1 and latency 4.
  always @(posedge clk) res1 <= aid1 + 16'd2;
  always @(posedge clk) begin
    pipe4[0] <= aid4 + 16'd2;
    for (int k = 1; k < 4; k++) pipe4[k] <= pipe4[k-1];
  end
  assign res4 = pipe4[3];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          idx;
    logic [15:0] data;
    int          due;
  } exp_t;

  exp_t q1[$];
  exp_t q4[$];
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, expv);
    end
  endtask

  // One cycle: drive inputs at the falling edge, check outputs 1ns later.
  task automatic step(input logic [3:0] v, input logic p, input int g);
    logic [3:0]  oh;
    logic [15:0] e;
    exp_t        item;
    @(negedge clk);
    req_valid = v;
    pause     = p;
    #1;
    oh = 4'b0001;
    oh = (g >= 0) ? (oh << g) : 4'b0000;
    chk("ready1", ready1, oh);
    chk("ready4", ready4, oh);
    chk("aiv1", aiv1, (g >= 0));
    chk("aiv4", aiv4, (g >= 0));
    chk("aid1", aid1, (g >= 0) ? dat[g] : 16'd0);
    chk("inflight1", inf1, q1.size());
    chk("inflight4", inf4, q4.size());
    if (q1.size() > 0 && q1[0].due == cyc) begin
      oh = 4'b0001;
      oh = oh << q1[0].idx;
      chk("rsp1_valid", rsp_v1, oh);
      chk("rsp1_data", rsp_d1, q1[0].data);
      void'(q1.pop_front());
    end else begin
      chk("rsp1_idle", rsp_v1, 4'b0000);
    end
    if (q4.size() > 0 && q4[0].due == cyc) begin
      oh = 4'b0001;
      oh = oh << q4[0].idx;
      chk("rsp4_valid", rsp_v4, oh);
      chk("rsp4_data", rsp_d4, q4[0].data);
      void'(q4.pop_front());
    end else begin
      chk("rsp4_idle", rsp_v4, 4'b0000);
    end
    if (g >= 0) begin
      e = dat[g] + 16'd2;
      item.idx = g; item.data = e;
      item.due = cyc + 1; q1.push_back(item);
      item.due = cyc + 4; q4.push_back(item);
    end
    $display("cyc=%0d valid=%b pause=%b grant=%0d ready=%b rsp1=%b rsp4=%b inflight4=%0d",
             cyc, v, p, g, ready1, rsp_v1, rsp_v4, inf4);
  endtask

  // Asynchronous reset pulse between edges, with all requesters valid meanwhile.
  task automatic pulse_rst();
    @(negedge clk);
    req_valid = 4'b1111;
    rst       = 1'b0;
    #1;
    chk("rst_ready1", ready1, 4'b0000);
    chk("rst_ready4", ready4, 4'b0000);
    chk("rst_aiv1", aiv1, 1'b0);
    chk("rst_inflight1", inf1, 1'b0);
    chk("rst_inflight4", inf4, 3'd0);
    chk("rst_rsp1", rsp_v1, 4'b0000);
    chk("rst_rsp4", rsp_v4, 4'b0000);
    q1.delete();
    q4.delete();
    req_valid = 4'b0000;
    #1;
    rst = 1'b1;
    $display("cyc=%0d reset pulse", cyc);
  endtask

  task automatic drain();
    for (int k = 0; k < 4; k++) step(4'b0000, 1'b0, -1);
  endtask

  initial begin
    rst       = 1'b0;
    pause     = 1'b0;
    req_valid = 4'b1111;
    for (int i = 0; i < 4; i++) dat[i] = 16'(i);

    // Reset held with everyone requesting.
    for (int k = 0; k < 3; k++) step(4'b1111, 1'b0, -1);
    @(negedge clk);
    req_valid = 4'b0000;
    rst       = 1'b1;

    // Single request from requester 2.
    dat[2] = 16'd10;
    step(4'b0100, 1'b0, 2);
    drain();

    // All four contending from a fresh pointer.
    pulse_rst();
    for (int i = 0; i < 4; i++) dat[i] = 16'(100 + i);
    step(4'b1111, 1'b0, 0);
    step(4'b1111, 1'b0, 1);
    step(4'b1111, 1'b0, 2);
    step(4'b1111, 1'b0, 3);
    step(4'b1111, 1'b0, 0);
    drain();

    // Fairness between requesters 0 and 3 (pointer at 0).
    step(4'b1001, 1'b0, 3);
    step(4'b1001, 1'b0, 0);
    step(4'b1001, 1'b0, 3);
    step(4'b1001, 1'b0, 0);
    drain();

    // Pause right after granting requester 1; its response still returns.
    dat[1] = 16'hfffe;
    step(4'b0010, 1'b0, 1);
    for (int k = 0; k < 5; k++) step(4'b1111, 1'b1, -1);
    step(4'b1111, 1'b0, 2);
    drain();

    // Reset mid-flight: three operations outstanding in the latency-4 instance.
    step(4'b1111, 1'b0, 3);
    step(4'b1111, 1'b0, 0);
    step(4'b1111, 1'b0, 1);
    pulse_rst();
    drain();
    step(4'b1111, 1'b0, 0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
